// File: rtl/ioctl_upload_responder_pkg.sv
// Shared types and constants for the ioctl save-data upload responder.
package gnw_ioctl_pkg;

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [7:0]  SAVE_INDEX_DEF = 8'd1;
  localparam int          IOCTL_ADDR_W   = 25;
  localparam int          IOCTL_DATA_W   = 16;
  localparam logic [15:0] TIMEOUT_FILL   = 16'hFFFF;

endpackage

// File: rtl/ioctl_upload_responder_if.sv
// ioctl upload bus plus the save-memory read port, seen from the responder (slave)
// and from hps_io / the core memory (master).
interface ioctl_upload_responder_if
  import gnw_ioctl_pkg::*;
#(
  parameter int MEM_ADDR_W = 12
);
  logic                    ioctl_upload;
  logic [7:0]              ioctl_index;
  logic                    ioctl_rd;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [IOCTL_DATA_W-1:0] ioctl_din;
  logic                    ioctl_wait;
  logic                    ioctl_upload_req;
  logic                    mem_rd_req;
  logic [MEM_ADDR_W-1:0]   mem_addr;
  logic                    mem_ack;
  logic [15:0]             mem_data;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_ack, mem_data,
    output ioctl_din, ioctl_wait, ioctl_upload_req, mem_rd_req, mem_addr
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_ack, mem_data,
    input  ioctl_din, ioctl_wait, ioctl_upload_req, mem_rd_req, mem_addr
  );
endinterface

// File: rtl/ioctl_upload_responder_rise_detect.sv
// Rising-edge detector: registered history of the level, pulse while level is newly high.
module gnw_rise_detect (
  input  logic clk_sys_99_287,
  input  logic RESET,
  input  logic level,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk_sys_99_287) begin
    if (RESET) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/ioctl_upload_responder.sv
// Save-data upload responder: serves HPS read strobes from core memory, tracks dirty, requests autosave.
// Optional fetch watchdog enabled by defining GNW_UPLOAD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a selected ioctl_rd
// FETCH | mem_rd_req held, HPS stalled via ioctl_wait until mem_ack
module ioctl_upload_responder
  import gnw_ioctl_pkg::*;
#(
  parameter int         MEM_ADDR_W     = 12,
  parameter logic [7:0] SAVE_INDEX     = SAVE_INDEX_DEF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic clk_sys_99_287,
  input  logic RESET,
  ioctl_upload_responder_if.slave bus,
  input  logic osd_status,
  input  logic dirty_wr,
  output logic dirty
`ifdef GNW_UPLOAD_TIMEOUT_EN
  ,output logic timeout_err
`endif
);
  state_t state;
  logic   index_match, rd_sel, upload_rise, osd_rise;
  logic   unused_addr;

  assign index_match = bus.ioctl_upload & (bus.ioctl_index == SAVE_INDEX);
  assign rd_sel      = bus.ioctl_rd & index_match;
  assign unused_addr = &{1'b0, bus.ioctl_addr[IOCTL_ADDR_W-1:MEM_ADDR_W+1], bus.ioctl_addr[0]};

  gnw_rise_detect u_upload_rise (
    .clk_sys_99_287 (clk_sys_99_287),
    .RESET          (RESET),
    .level          (index_match),
    .rise           (upload_rise)
  );

  gnw_rise_detect u_osd_rise (
    .clk_sys_99_287 (clk_sys_99_287),
    .RESET          (RESET),
    .level          (osd_status),
    .rise           (osd_rise)
  );

`ifdef GNW_UPLOAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_sys_99_287) begin
    if (RESET) begin
      state          <= IDLE;
      bus.ioctl_din  <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.mem_rd_req <= 1'b0;
      bus.mem_addr   <= '0;
`ifdef GNW_UPLOAD_TIMEOUT_EN
      to_cnt         <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (rd_sel) begin
          bus.mem_addr   <= bus.ioctl_addr[MEM_ADDR_W:1];
          bus.mem_rd_req <= 1'b1;
          bus.ioctl_wait <= 1'b1;
`ifdef GNW_UPLOAD_TIMEOUT_EN
          to_cnt         <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
          state          <= FETCH;
        end
        FETCH: begin
          // Ack is checked first so a same-cycle ack beats the watchdog.
          if (bus.mem_ack) begin
            bus.ioctl_din  <= bus.mem_data;
            bus.mem_rd_req <= 1'b0;
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
          end
`ifdef GNW_UPLOAD_TIMEOUT_EN
          else if (to_cnt == '0) begin
            bus.ioctl_din  <= TIMEOUT_FILL;
            bus.mem_rd_req <= 1'b0;
            bus.ioctl_wait <= 1'b0;
            timeout_err    <= 1'b1;
            state          <= IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys_99_287) begin
    if (RESET) begin
      dirty                <= 1'b0;
      bus.ioctl_upload_req <= 1'b0;
    end else begin
      if (dirty_wr)         dirty <= 1'b1;
      else if (upload_rise) dirty <= 1'b0;
      bus.ioctl_upload_req <= osd_rise & dirty & ~bus.ioctl_upload;
    end
  end
endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Bench for ioctl_upload_responder: vector table, hand-written corner sequences, random reads and dirty/autosave.
module tb_ioctl_upload_responder;
  localparam logic [7:0] SAVE_IDX = 8'd1;

  logic clk = 1'b0;
  logic RESET;
  logic osd_status, dirty_wr, dirty;
  logic timeout_err;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] last_din;
  logic [15:0] mem_model [4096];

  always #5 clk = ~clk;

  ioctl_upload_responder_if #(.MEM_ADDR_W(12)) bus ();

  ioctl_upload_responder #(
    .MEM_ADDR_W     (12),
    .SAVE_INDEX     (SAVE_IDX),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_sys_99_287 (clk),
    .RESET          (RESET),
    .bus            (bus),
    .osd_status     (osd_status),
    .dirty_wr       (dirty_wr),
    .dirty          (dirty)
`ifdef GNW_UPLOAD_TIMEOUT_EN
    ,.timeout_err   (timeout_err)
`endif
  );

`ifndef GNW_UPLOAD_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [7:0]  idx;
    logic        up;
    logic [24:0] addr;
    logic [15:0] data;
    int          dly;
    logic        exp_sel;
    logic [11:0] exp_maddr;
    logic [15:0] exp_din;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_read(input string nm, input logic [7:0] idx, input logic up,
                         input logic [24:0] addr, input logic [15:0] data, input int dly,
                         input bit use_mem, input bit spur, input logic exp_sel,
                         input logic [11:0] exp_maddr, input logic [15:0] exp_din);
    logic [15:0] d;
    bus.ioctl_index  = idx;
    bus.ioctl_upload = up;
    bus.ioctl_addr   = addr;
    bus.ioctl_rd     = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    chk({nm, "_wait1"}, 32'(bus.ioctl_wait), 32'(exp_sel));
    chk({nm, "_req1"}, 32'(bus.mem_rd_req), 32'(exp_sel));
    if (exp_sel) begin
      chk({nm, "_maddr"}, 32'(bus.mem_addr), 32'(exp_maddr));
      for (int i = 0; i < dly; i++) begin
        if (spur && $urandom_range(1) == 1) begin
          bus.ioctl_addr = 25'($urandom);
          bus.ioctl_rd   = 1'b1;
        end
        tick();
        bus.ioctl_rd = 1'b0;
        chk({nm, "_wait_hold"}, 32'(bus.ioctl_wait), 32'd1);
        chk({nm, "_maddr_hold"}, 32'(bus.mem_addr), 32'(exp_maddr));
      end
      d = use_mem ? mem_model[bus.mem_addr] : data;
    end else begin
      d = data;
    end
    // in the unselected case this is an ack while idle, which must be ignored
    bus.mem_ack  = 1'b1;
    bus.mem_data = d;
    tick();
    bus.mem_ack  = 1'b0;
    bus.mem_data = 16'($urandom);
    chk({nm, "_wait_end"}, 32'(bus.ioctl_wait), 32'd0);
    chk({nm, "_req_end"}, 32'(bus.mem_rd_req), 32'd0);
    chk({nm, "_din"}, 32'(bus.ioctl_din), 32'(exp_din));
    last_din = exp_din;
  endtask

  task automatic apply_reset;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    last_din = 16'h0;
  endtask

  initial begin
    vec_t vecs [7];
    int   pulses;
    logic m_dirty, m_req, p_osd, p_match, match, ue, oe, n_req, n_dirty;

    RESET = 1'b1;
    osd_status = 1'b0;
    dirty_wr = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = 16'h0;
    last_din = 16'h0;
    foreach (mem_model[i]) mem_model[i] = 16'($urandom);

    tick();
    tick();
    tick();
    chk("rst_din", 32'(bus.ioctl_din), 32'd0);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_ureq", 32'(bus.ioctl_upload_req), 32'd0);
    chk("rst_req", 32'(bus.mem_rd_req), 32'd0);
    chk("rst_maddr", 32'(bus.mem_addr), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    RESET = 1'b0;
    tick();

    vecs[0] = '{"base",   8'd1, 1'b1, 25'h0000006, 16'hBEEF, 2, 1'b1, 12'h003, 16'hBEEF};
    vecs[1] = '{"idxmis", 8'd0, 1'b1, 25'h0000008, 16'h1111, 0, 1'b0, 12'h000, 16'hBEEF};
    vecs[2] = '{"noupld", 8'd1, 1'b0, 25'h0000008, 16'h2222, 0, 1'b0, 12'h000, 16'hBEEF};
    vecs[3] = '{"bit0",   8'd1, 1'b1, 25'h0000007, 16'h0A55, 0, 1'b1, 12'h003, 16'h0A55};
    vecs[4] = '{"wrap",   8'd1, 1'b1, 25'h1FFFFFE, 16'h1234, 1, 1'b1, 12'hFFF, 16'h1234};
    vecs[5] = '{"alias",  8'd1, 1'b1, 25'h0002002, 16'h5678, 4, 1'b1, 12'h001, 16'h5678};
    vecs[6] = '{"idx2",   8'd2, 1'b1, 25'h0000004, 16'h3333, 0, 1'b0, 12'h000, 16'h5678};
    foreach (vecs[i])
      do_read(vecs[i].nm, vecs[i].idx, vecs[i].up, vecs[i].addr, vecs[i].data, vecs[i].dly,
              1'b0, 1'b0, vecs[i].exp_sel, vecs[i].exp_maddr, vecs[i].exp_din);

    // dirty tracking and autosave pulse
    bus.ioctl_upload = 1'b0;
    tick();
    chk("dirty_idle", 32'(dirty), 32'd0);
    dirty_wr = 1'b1;
    tick();
    dirty_wr = 1'b0;
    chk("dirty_set", 32'(dirty), 32'd1);
    osd_status = 1'b1;
    tick();
    chk("osd_req", 32'(bus.ioctl_upload_req), 32'd1);
    tick();
    chk("req_1cyc", 32'(bus.ioctl_upload_req), 32'd0);
    pulses = 0;
    repeat (5) begin
      tick();
      pulses += int'(bus.ioctl_upload_req);
    end
    chk("no_repulse", 32'(pulses), 32'd0);
    osd_status = 1'b0;
    tick();
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index = SAVE_IDX;
    tick();
    chk("upl_clr", 32'(dirty), 32'd0);
    osd_status = 1'b1;
    tick();
    chk("osd_clean", 32'(bus.ioctl_upload_req), 32'd0);
    osd_status = 1'b0;
    bus.ioctl_upload = 1'b0;
    tick();
    dirty_wr = 1'b1;
    bus.ioctl_upload = 1'b1;
    tick();
    dirty_wr = 1'b0;
    chk("coinc", 32'(dirty), 32'd1);
    tick();
    chk("coinc_hold", 32'(dirty), 32'd1);
    osd_status = 1'b1;
    tick();
    chk("osd_in_upl", 32'(bus.ioctl_upload_req), 32'd0);
    osd_status = 1'b0;
    bus.ioctl_upload = 1'b0;
    tick();

    // reset in the middle of a fetch, then a stray ack
    bus.ioctl_upload = 1'b1;
    bus.ioctl_addr = 25'h10;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mrst_din", 32'(bus.ioctl_din), 32'd0);
    chk("mrst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("mrst_req", 32'(bus.mem_rd_req), 32'd0);
    chk("mrst_maddr", 32'(bus.mem_addr), 32'd0);
    chk("mrst_dirty", 32'(dirty), 32'd0);
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'hCAFE;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_din", 32'(bus.ioctl_din), 32'd0);
    chk("late_ack_wait", 32'(bus.ioctl_wait), 32'd0);
    last_din = 16'h0;
    do_read("post_rst", SAVE_IDX, 1'b1, 25'h20, 16'h4242, 0, 1'b0, 1'b0, 1'b1, 12'h010, 16'h4242);

`ifdef GNW_UPLOAD_TIMEOUT_EN
    do_read("ack_vs_to", SAVE_IDX, 1'b1, 25'h40, 16'h9999, 15, 1'b0, 1'b0, 1'b1, 12'h020, 16'h9999);
    chk("ack_vs_to_terr", 32'(timeout_err), 32'd0);
    bus.ioctl_addr = 25'h44;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    chk("to_wait16", 32'(bus.ioctl_wait), 32'd1);
    tick();
    chk("to_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("to_req", 32'(bus.mem_rd_req), 32'd0);
    chk("to_din", 32'(bus.ioctl_din), 32'hFFFF);
    chk("to_terr", 32'(timeout_err), 32'd1);
    last_din = 16'hFFFF;
    tick();
    chk("to_terr_sticky", 32'(timeout_err), 32'd1);
`endif

    // random reads checked against the word-addressed memory model
    for (int n = 0; n < 60; n++) begin
      logic [7:0]  idx;
      logic        up, sel;
      logic [24:0] addr;
      logic [11:0] waddr;
      idx  = ($urandom_range(3) == 0) ? 8'($urandom_range(7)) : SAVE_IDX;
      up   = ($urandom_range(5) != 0);
      addr = 25'($urandom);
      sel  = up && (idx == SAVE_IDX);
      waddr = 12'((addr / 2) % 4096);
      do_read("rnd", idx, up, addr, 16'($urandom), $urandom_range(10), 1'b1, 1'b1,
              sel, waddr, sel ? mem_model[waddr] : last_din);
    end

    // random dirty/autosave traffic against a rule-level model
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd0;
    osd_status = 1'b0;
    dirty_wr = 1'b0;
    apply_reset();
    m_dirty = 1'b0;
    m_req = 1'b0;
    p_osd = 1'b0;
    p_match = 1'b0;
    for (int n = 0; n < 300; n++) begin
      dirty_wr = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) osd_status = ~osd_status;
      if ($urandom_range(5) == 0) bus.ioctl_upload = ~bus.ioctl_upload;
      if ($urandom_range(7) == 0) bus.ioctl_index = ($urandom_range(2) == 0) ? 8'd3 : SAVE_IDX;
      match   = bus.ioctl_upload && (bus.ioctl_index == SAVE_IDX);
      ue      = match && !p_match;
      oe      = osd_status && !p_osd;
      n_req   = oe && m_dirty && !bus.ioctl_upload;
      n_dirty = dirty_wr ? 1'b1 : (ue ? 1'b0 : m_dirty);
      p_match = match;
      p_osd   = osd_status;
      m_dirty = n_dirty;
      m_req   = n_req;
      tick();
      chk("rnd_dirty", 32'(dirty), 32'(m_dirty));
      chk("rnd_ureq", 32'(bus.ioctl_upload_req), 32'(m_req));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
